// File: rtl/mc_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the datapath.
// The master side (control unit) consumes opcode/flags and drives controls.
interface mc_control_unit_if;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       DBDataSrc;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic [1:0] PCSrc;

  modport master (
    input  opcode, zero, sign,
    output state, PCWre, IRWre, InsMemRW,
    output ALUOp, ALUSrcA, ALUSrcB, ExtSel,
    output RegDst, WrRegDSrc, DBDataSrc,
    output RegWre, mRD, mWR, PCSrc
  );

  modport slave (
    output opcode, zero, sign,
    input  state, PCWre, IRWre, InsMemRW,
    input  ALUOp, ALUSrcA, ALUSrcB, ExtSel,
    input  RegDst, WrRegDSrc, DBDataSrc,
    input  RegWre, mRD, mWR, PCSrc
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and
// drives ALU function, datapath muxes and write enables.
module mc_control_unit (
  input logic               CLK,
  input logic               RST,
  mc_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  state_t cur;
  state_t nxt;

  logic is_add, is_sub, is_addiu, is_and;
  logic is_andi, is_ori, is_xori, is_sll;
  logic is_slti, is_slt, is_sw, is_lw;
  logic is_beq, is_bne, is_bltz;
  logic is_j, is_jr, is_jal, is_halt;
  logic is_alu, is_br, is_ls, is_jmp;
  logic br_taken;

  assign is_add   = bus.opcode == OP_ADD;
  assign is_sub   = bus.opcode == OP_SUB;
  assign is_addiu = bus.opcode == OP_ADDIU;
  assign is_and   = bus.opcode == OP_AND;
  assign is_andi  = bus.opcode == OP_ANDI;
  assign is_ori   = bus.opcode == OP_ORI;
  assign is_xori  = bus.opcode == OP_XORI;
  assign is_sll   = bus.opcode == OP_SLL;
  assign is_slti  = bus.opcode == OP_SLTI;
  assign is_slt   = bus.opcode == OP_SLT;
  assign is_sw    = bus.opcode == OP_SW;
  assign is_lw    = bus.opcode == OP_LW;
  assign is_beq   = bus.opcode == OP_BEQ;
  assign is_bne   = bus.opcode == OP_BNE;
  assign is_bltz  = bus.opcode == OP_BLTZ;
  assign is_j     = bus.opcode == OP_J;
  assign is_jr    = bus.opcode == OP_JR;
  assign is_jal   = bus.opcode == OP_JAL;
  assign is_halt  = bus.opcode == OP_HALT;

  assign is_alu = is_add | is_sub | is_addiu | is_and
                | is_andi | is_ori | is_xori | is_sll
                | is_slti | is_slt;
  assign is_br  = is_beq | is_bne | is_bltz;
  assign is_ls  = is_sw | is_lw;
  assign is_jmp = is_j | is_jr | is_jal;

  assign br_taken = (is_beq & bus.zero)
                  | (is_bne & ~bus.zero)
                  | (is_bltz & bus.sign);

  // ALU-class decode, shared by S_EXE_AL and S_WB_AL
  logic [2:0] al_op;
  logic       al_imm;
  logic       al_sha;
  logic       al_ext;
  logic       al_rtype;

  always_comb begin
    al_op    = 3'b000;
    al_imm   = 1'b0;
    al_sha   = 1'b0;
    al_ext   = 1'b1;
    al_rtype = 1'b0;
    unique case (1'b1)
      is_add: al_rtype = 1'b1;
      is_sub: begin
        al_op    = 3'b001;
        al_rtype = 1'b1;
      end
      is_addiu: al_imm = 1'b1;
      is_and: begin
        al_op    = 3'b110;
        al_rtype = 1'b1;
      end
      is_andi: begin
        al_op  = 3'b110;
        al_imm = 1'b1;
        al_ext = 1'b0;
      end
      is_ori: begin
        al_op  = 3'b101;
        al_imm = 1'b1;
        al_ext = 1'b0;
      end
      is_xori: begin
        al_op  = 3'b111;
        al_imm = 1'b1;
        al_ext = 1'b0;
      end
      is_sll: begin
        al_op    = 3'b100;
        al_sha   = 1'b1;
        al_rtype = 1'b1;
      end
      is_slti: begin
        al_op  = 3'b011;
        al_imm = 1'b1;
      end
      is_slt: begin
        al_op    = 3'b011;
        al_rtype = 1'b1;
      end
      default: al_op = 3'b000;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) cur <= S_IF;
    else     cur <= nxt;
  end

  logic       pc_wre;
  logic       ir_wre;
  logic       ins_rd;
  logic [2:0] alu_op;
  logic       src_a;
  logic       src_b;
  logic       ext_sel;
  logic [1:0] reg_dst;
  logic       wr_src;
  logic       db_src;
  logic       reg_wre;
  logic       m_rd;
  logic       m_wr;
  logic [1:0] pc_src;

  always_comb begin
    nxt     = cur;
    pc_wre  = 1'b0;
    ir_wre  = 1'b0;
    ins_rd  = 1'b0;
    alu_op  = 3'b000;
    src_a   = 1'b0;
    src_b   = 1'b0;
    ext_sel = 1'b0;
    reg_dst = 2'b00;
    wr_src  = 1'b0;
    db_src  = 1'b0;
    reg_wre = 1'b0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    pc_src  = 2'b00;
    // Reset masks every strobe so an abandoned instruction writes nothing
    if (RST) begin
      nxt = S_IF;
    end else begin
      unique case (cur)
        S_IF: begin
          ir_wre = 1'b1;
          ins_rd = 1'b1;
          nxt    = S_ID;
        end
        S_ID: begin
          unique case (1'b1)
            is_halt: nxt = S_ID;
            is_jmp: begin
              pc_wre = 1'b1;
              pc_src = is_jr ? 2'b10 : 2'b11;
              if (is_jal) begin
                reg_wre = 1'b1;
                reg_dst = 2'b10;
                wr_src  = 1'b0;
              end
              nxt = S_IF;
            end
            is_br:  nxt = S_EXE_BR;
            is_ls:  nxt = S_EXE_LS;
            is_alu: nxt = S_EXE_AL;
            default: begin
              pc_wre = 1'b1;
              nxt    = S_IF;
            end
          endcase
        end
        S_EXE_AL: begin
          alu_op  = al_op;
          src_a   = al_sha;
          src_b   = al_imm;
          ext_sel = al_ext;
          nxt     = S_WB_AL;
        end
        S_WB_AL: begin
          alu_op  = al_op;
          src_a   = al_sha;
          src_b   = al_imm;
          ext_sel = al_ext;
          reg_wre = 1'b1;
          db_src  = 1'b0;
          wr_src  = 1'b1;
          reg_dst = al_rtype ? 2'b01 : 2'b00;
          pc_wre  = 1'b1;
          nxt     = S_IF;
        end
        S_EXE_BR: begin
          alu_op = 3'b001;
          src_b  = 1'b0;
          pc_wre = 1'b1;
          pc_src = br_taken ? 2'b01 : 2'b00;
          nxt    = S_IF;
        end
        S_EXE_LS: begin
          alu_op  = 3'b000;
          src_b   = 1'b1;
          ext_sel = 1'b1;
          nxt     = S_MEM;
        end
        S_MEM: begin
          if (is_sw) begin
            m_wr   = 1'b1;
            pc_wre = 1'b1;
            nxt    = S_IF;
          end else begin
            m_rd = 1'b1;
            nxt  = S_WB_LD;
          end
        end
        S_WB_LD: begin
          m_rd    = 1'b1;
          reg_wre = 1'b1;
          db_src  = 1'b1;
          wr_src  = 1'b1;
          reg_dst = 2'b00;
          pc_wre  = 1'b1;
          nxt     = S_IF;
        end
      endcase
    end
  end

  assign bus.state     = cur;
  assign bus.PCWre     = pc_wre;
  assign bus.IRWre     = ir_wre;
  assign bus.InsMemRW  = ins_rd;
  assign bus.ALUOp     = alu_op;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ExtSel    = ext_sel;
  assign bus.RegDst    = reg_dst;
  assign bus.WrRegDSrc = wr_src;
  assign bus.DBDataSrc = db_src;
  assign bus.RegWre    = reg_wre;
  assign bus.mRD       = m_rd;
  assign bus.mWR       = m_wr;
  assign bus.PCSrc     = pc_src;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: driver pushes expected
// per-cycle control words, a negedge monitor pops and compares.
module tb_mc_control_unit;

  logic clk;
  logic rst;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       imr;
    logic [2:0] aop;
    logic       sa;
    logic       sb;
    logic       ext;
    logic [1:0] rdst;
    logic       wrs;
    logic       dbs;
    logic       rgw;
    logic       mrd;
    logic       mwr;
    logic [1:0] pcs;
  } out_t;

  typedef struct {
    out_t  v;
    out_t  c;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  typedef enum {C_ALU, C_BR, C_SW, C_LW, C_JMP, C_NOP, C_HALT} cls_t;

  function automatic cls_t cls_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b010011, 6'b011000,
      6'b100110, 6'b100111:             return C_ALU;
      6'b110100, 6'b110101, 6'b110110:  return C_BR;
      6'b110000:                        return C_SW;
      6'b110001:                        return C_LW;
      6'b111000, 6'b111001, 6'b111010:  return C_JMP;
      6'b111111:                        return C_HALT;
      default:                          return C_NOP;
    endcase
  endfunction

  function automatic int cycles_of(input logic [5:0] op);
    case (cls_of(op))
      C_ALU:   return 4;
      C_BR:    return 3;
      C_SW:    return 4;
      C_LW:    return 5;
      C_HALT:  return 21;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op);
    case (op)
      6'b000001:           return 3'b001;
      6'b010000, 6'b010001: return 3'b110;
      6'b010010:           return 3'b101;
      6'b010011:           return 3'b111;
      6'b011000:           return 3'b100;
      6'b100110, 6'b100111: return 3'b011;
      default:             return 3'b000;
    endcase
  endfunction

  function automatic bit is_imm(input logic [5:0] op);
    return op inside {6'b000010, 6'b010001, 6'b010010,
                      6'b010011, 6'b100110};
  endfunction

  function automatic exp_t base(input logic [2:0] st, input string tag);
    exp_t e;
    e.v = '0;
    e.c = '0;
    e.v.st = st;
    e.c.st = '1;
    e.c.pcw = 1'b1;
    e.c.irw = 1'b1;
    e.c.imr = 1'b1;
    e.c.aop = '1;
    e.c.rgw = 1'b1;
    e.c.mrd = 1'b1;
    e.c.mwr = 1'b1;
    e.c.pcs = '1;
    e.tag = tag;
    return e;
  endfunction

  // Expected controls for step k of an instruction (k=0 is fetch)
  function automatic exp_t model(input logic [5:0] op, input int k,
                                 input bit z, input bit s);
    exp_t  e;
    cls_t  c;
    string t;
    bit    taken;
    c = cls_of(op);
    t = $sformatf("op%b_k%0d", op, k);
    if (k == 0) begin
      e = base(3'b000, t);
      e.v.irw = 1'b1;
      e.v.imr = 1'b1;
      return e;
    end
    if (k == 1 || c == C_HALT) begin
      e = base(3'b001, t);
      if (c == C_JMP) begin
        e.v.pcw = 1'b1;
        e.v.pcs = (op == 6'b111001) ? 2'b10 : 2'b11;
        if (op == 6'b111010) begin
          e.v.rgw  = 1'b1;
          e.v.rdst = 2'b10;
          e.c.rdst = '1;
          e.v.wrs  = 1'b0;
          e.c.wrs  = 1'b1;
        end
      end else if (c == C_NOP) begin
        e.v.pcw = 1'b1;
      end
      return e;
    end
    case (c)
      C_BR: begin
        e = base(3'b101, t);
        taken = (op == 6'b110100 && z) || (op == 6'b110101 && !z)
             || (op == 6'b110110 && s);
        e.v.aop = 3'b001;
        e.c.sb  = 1'b1;
        e.v.pcw = 1'b1;
        e.v.pcs = taken ? 2'b01 : 2'b00;
      end
      C_ALU: begin
        e = base(k == 2 ? 3'b110 : 3'b111, t);
        e.v.aop = aluop_of(op);
        e.c.sa  = 1'b1;
        e.v.sa  = (op == 6'b011000);
        e.c.sb  = 1'b1;
        e.v.sb  = is_imm(op);
        if (is_imm(op)) begin
          e.c.ext = 1'b1;
          e.v.ext = !(op inside {6'b010001, 6'b010010, 6'b010011});
        end
        if (k == 3) begin
          e.v.rgw  = 1'b1;
          e.c.dbs  = 1'b1;
          e.v.wrs  = 1'b1;
          e.c.wrs  = 1'b1;
          e.c.rdst = '1;
          e.v.rdst = is_imm(op) ? 2'b00 : 2'b01;
          e.v.pcw  = 1'b1;
        end
      end
      default: begin
        if (k == 2) begin
          e = base(3'b010, t);
          e.c.sb  = 1'b1;
          e.v.sb  = 1'b1;
          e.c.ext = 1'b1;
          e.v.ext = 1'b1;
        end else if (k == 3) begin
          e = base(3'b011, t);
          if (c == C_SW) begin
            e.v.mwr = 1'b1;
            e.v.pcw = 1'b1;
          end else begin
            e.v.mrd = 1'b1;
          end
        end else begin
          e = base(3'b100, t);
          e.v.mrd  = 1'b1;
          e.v.rgw  = 1'b1;
          e.c.dbs  = 1'b1;
          e.v.dbs  = 1'b1;
          e.c.wrs  = 1'b1;
          e.v.wrs  = 1'b1;
          e.c.rdst = '1;
          e.v.pcw  = 1'b1;
        end
      end
    endcase
    return e;
  endfunction

  function automatic exp_t rst_exp(input bit st_known, input string tag);
    exp_t e;
    e.v = '0;
    e.c = '0;
    e.c.pcw = 1'b1;
    e.c.irw = 1'b1;
    e.c.rgw = 1'b1;
    e.c.mrd = 1'b1;
    e.c.mwr = 1'b1;
    if (st_known) e.c.st = '1;
    e.tag = tag;
    return e;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.push_back(rst_exp(i > 0, $sformatf("reset_%0d", i)));
    end
  endtask

  // zf/sf < 0 means random flag values each cycle
  task automatic run_instr(input logic [5:0] op, input int zf,
                           input int sf, input int abort_k);
    int n;
    n = cycles_of(op);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) bus.opcode = op;
      bus.zero = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
      bus.sign = (sf < 0) ? 1'($urandom_range(0, 1)) : sf[0];
      if (k == abort_k) begin
        rst = 1'b1;
        exp_q.push_back(rst_exp(1'b1, $sformatf("abort_op%b", op)));
        exp_q.push_back(rst_exp(1'b0, "abort_hold"));
        exp_q.pop_back();
        return;
      end
      rst = 1'b0;
      exp_q.push_back(model(op, k, bus.zero, bus.sign));
    end
  endtask

  // Abort cycle shows the state entered before reset took effect
  task automatic fix_abort_state(input logic [2:0] st);
    exp_t e;
    e = exp_q.pop_back();
    e.v.st = st;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    out_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = '{st: bus.state, pcw: bus.PCWre, irw: bus.IRWre,
                imr: bus.InsMemRW, aop: bus.ALUOp, sa: bus.ALUSrcA,
                sb: bus.ALUSrcB, ext: bus.ExtSel, rdst: bus.RegDst,
                wrs: bus.WrRegDSrc, dbs: bus.DBDataSrc,
                rgw: bus.RegWre, mrd: bus.mRD, mwr: bus.mWR,
                pcs: bus.PCSrc};
        total++;
        if (((act ^ e.v) & e.c) == '0) passed++;
        else $display("FAIL %s: got %h want %h care %h",
                      e.tag, act, e.v, e.c);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [5:0] pool [19];
  initial begin : driver
    logic [5:0] op;
    pool = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
             6'b010010, 6'b010011, 6'b011000, 6'b100110, 6'b100111,
             6'b110000, 6'b110001, 6'b110100, 6'b110101, 6'b110110,
             6'b111000, 6'b111001, 6'b111010, 6'b001000};
    rst = 1'b1;
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    bus.sign = 1'b0;
    @(posedge clk);
    do_reset(2);
    run_instr(6'b000000, -1, -1, -1);
    run_instr(6'b110100, 1, -1, -1);
    run_instr(6'b110100, 0, -1, -1);
    run_instr(6'b110101, 0, -1, -1);
    run_instr(6'b110110, -1, 1, -1);
    run_instr(6'b110110, -1, 0, -1);
    run_instr(6'b110001, -1, -1, -1);
    run_instr(6'b110000, -1, -1, -1);
    run_instr(6'b111010, -1, -1, -1);
    run_instr(6'b111001, -1, -1, -1);
    run_instr(6'b011000, -1, -1, -1);
    run_instr(6'b010010, -1, -1, -1);
    run_instr(6'b101010, -1, -1, -1);
    run_instr(6'b111111, -1, -1, -1);
    do_reset(2);
    run_instr(6'b110000, -1, -1, 3);
    fix_abort_state(3'b011);
    run_instr(6'b110001, -1, -1, 4);
    fix_abort_state(3'b100);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        if (op == 6'b111111) op = 6'b000000;
      end else begin
        op = pool[$urandom_range(0, 18)];
      end
      run_instr(op, -1, -1, -1);
    end
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d left want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
